// File: rtl/qsys_pio_pkg.sv
// qsys_pio_pkg: register addresses and edge-type selectors shared by the input PIO
package qsys_pio_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: accepts a new level only after DEBOUNCE_CYCLES consecutive differing cycles
module pio_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic db_q, db_d, done;
   // count differing cycles; any agreeing cycle restarts the count
   always_comb begin
      done  = (d_i != db_q) && (cnt_q == LAST);
      cnt_d = (d_i == db_q || done) ? '0 : cnt_q + 1'b1;
      db_d  = done ? d_i : db_q;
   end
   // debounce state register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         db_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end
   assign q_o = db_q;
endmodule

// File: rtl/qsys_pio_input_irq.sv
// qsys_pio_input_irq: Avalon-MM input PIO with debounce, edge capture and maskable irq
module qsys_pio_input_irq
   import qsys_pio_pkg::*;
#(
   parameter int WIDTH           = 18,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] sync1_q, sync2_q, db, db_prev_q;
   logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, rise, fall, edges;
   logic [31:0] rdata_q, rdata_d;
   logic wr, unused_wd;
   assign unused_wd = ^writedata;
   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign db = sync2_q;
      end else begin : g_db
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
               .clk(clk), .reset(reset), .d_i(sync2_q[i]), .q_o(db[i]));
         end
      end
   endgenerate
   // edge selection, register updates and read mux
   always_comb begin
      wr      = chipselect && !write_n;
      rise    = db & ~db_prev_q;
      fall    = ~db & db_prev_q;
      edges   = EDGE_TYPE == EDGE_RISE ? rise : EDGE_TYPE == EDGE_FALL ? fall : rise | fall;
      cap_d   = (wr && address == ADDR_EDGECAP ? cap_q & ~writedata[WIDTH-1:0] : cap_q) | edges;
      mask_d  = wr && address == ADDR_IRQMASK ? writedata[WIDTH-1:0] : mask_q;
      rdata_d = address == ADDR_DATA    ? 32'(db) :
                address == ADDR_IRQMASK ? 32'(mask_q) :
                address == ADDR_EDGECAP ? 32'(cap_q) : '0;
   end
   // synchroniser, edge history and software-visible registers
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_prev_q <= '0;
         mask_q    <= '0;
         cap_q     <= '0;
         rdata_q   <= '0;
      end else begin
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
         db_prev_q <= db;
         mask_q    <= mask_d;
         cap_q     <= cap_d;
         rdata_q   <= rdata_d;
      end
   end
   assign readdata = rdata_q;
   assign irq      = |(cap_q & mask_q);
endmodule
